// File: rtl/map_pkg.sv
// Shared definitions for the Pacman map tile store.
//   Grid geometry, tile type codes, FSM state encoding, address/range
//   helpers and the default map image used to fill the ROM.
package map_pkg;

    localparam int GRID_W  = 21;
    localparam int GRID_H  = 21;
    localparam int TYPE_W  = 4;
    localparam int ADDR_W  = 9;
    localparam int COORD_W = 5;
    localparam int CNT_W   = 9;
    localparam int TILES   = GRID_W * GRID_H;

    localparam logic [TYPE_W-1:0] TILE_BLACK     = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] TILE_BIG_ORB   = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TILE_SMALL_ORB = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] TILE_WALL      = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] TILE_GREY      = TYPE_W'(4);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(GRID_H - 1);
    localparam logic [CNT_W-1:0]   ORB_MAX = CNT_W'(TILES);

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_IDLE      = 2'd1,
        ST_WR_READ   = 2'd2,
        ST_WR_COMMIT = 2'd3
    } state_t;

    function automatic logic is_orb(input logic [TYPE_W-1:0] t);
        return (t == TILE_BIG_ORB) || (t == TILE_SMALL_ORB);
    endfunction

    function automatic logic in_grid(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
        return (x <= X_LAST) && (y <= Y_LAST);
    endfunction

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
    endfunction

    // Default level: wall border, big orbs in the four inner corners, a grey
    // ghost-house tile in the centre, wall pillars on a 4x4 lattice, empty
    // tiles on every 7th anti-diagonal, small orbs everywhere else.
    function automatic logic [TYPE_W-1:0] default_tile(input int x, input int y);
        if (x == 0 || y == 0 || x == GRID_W - 1 || y == GRID_H - 1)
            return TILE_WALL;
        if ((x == 1 || x == GRID_W - 2) && (y == 1 || y == GRID_H - 2))
            return TILE_BIG_ORB;
        if (x == GRID_W / 2 && y == GRID_H / 2)
            return TILE_GREY;
        if ((x % 4) == 2 && (y % 4) == 2)
            return TILE_WALL;
        if (((x + y) % 7) == 0)
            return TILE_BLACK;
        return TILE_SMALL_ORB;
    endfunction

endpackage

// File: rtl/map_rom.sv
// Default map ROM.
//   clock_50 : system clock
//   addr     : linear tile address (y*GRID_W + x)
//   data     : tile type, registered (1-cycle latency); 0 beyond the grid
// Contents come from map_pkg::default_tile so the image lives in one place.
module map_rom
    import map_pkg::*;
(
    input  logic              clock_50,
    input  logic [ADDR_W-1:0] addr,
    output logic [TYPE_W-1:0] data
);

    function automatic logic [TYPE_W-1:0] lookup(input logic [ADDR_W-1:0] a);
        int idx;
        idx = int'(a);
        if (idx >= TILES)
            return TILE_BLACK;
        return default_tile(idx % GRID_W, idx / GRID_W);
    endfunction

    always_ff @(posedge clock_50) begin
        data <= lookup(addr);
    end

endmodule

// File: rtl/map_tile_store.sv
// Pacman map tile store.
//   clock_50    : system clock
//   reset       : synchronous, active-low
//   x_in, y_in  : display read coordinate; type_out follows one cycle later
//   type_out    : tile type (0 while not ready or out of range)
//   wr_req/wr_x/wr_y/wr_type, wr_ack : tile write handshake (ack = 1-cycle pulse)
//   restore     : 1-cycle pulse, reload the default map
//   ready       : map loaded, writes accepted
//   orb_count   : number of tiles holding a big or small orb
//   level_clear : 1-cycle pulse when a write removes the last orb
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_INIT      | copy ROM to RAM, one tile per cycle, counting orbs
// ST_IDLE      | map ready, waiting for restore or a write request
// ST_WR_READ   | fetch the old tile at the write address
// ST_WR_COMMIT | store new tile, adjust orb_count, pulse wr_ack
module map_tile_store
    import map_pkg::*;
(
    input  logic               clock_50,
    input  logic               reset,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    output logic [TYPE_W-1:0]  type_out,
    input  logic               wr_req,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [TYPE_W-1:0]  wr_type,
    output logic               wr_ack,
    input  logic               restore,
    output logic               ready,
    output logic [CNT_W-1:0]   orb_count,
    output logic               level_clear
);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   load_cnt;
    logic [TYPE_W-1:0]   rom_q;
    logic [TYPE_W-1:0]   ram [TILES];
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [TYPE_W-1:0]   wr_type_q;
    logic                wr_valid_q;
    logic [TYPE_W-1:0]   old_q;
    logic                restore_pend;
    logic                go_init;
    logic                load_done;
    logic                ready_next;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [TYPE_W-1:0]   ram_wdata;

    map_rom u_rom (
        .clock_50 (clock_50),
        .addr     (load_cnt),
        .data     (rom_q)
    );

    always_comb begin
        state_next = state;
        go_init    = restore | restore_pend;
        load_done  = (load_cnt == ADDR_W'(TILES));
        case (state)
            ST_INIT:      if (load_done) state_next = ST_IDLE;
            ST_IDLE: begin
                if (go_init)     state_next = ST_INIT;
                else if (wr_req) state_next = ST_WR_READ;
            end
            ST_WR_READ:   state_next = ST_WR_COMMIT;
            ST_WR_COMMIT: state_next = go_init ? ST_INIT : ST_IDLE;
            default:      state_next = ST_INIT;
        endcase
        ready_next = (state_next != ST_INIT);
    end

    // ROM data lags its address by one cycle, so load write k lands while
    // load_cnt == k+1. A write is suppressed on a reset edge so that an
    // aborted commit leaves the RAM untouched.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (reset) begin
            if (state == ST_INIT && load_cnt != '0) begin
                ram_we    = 1'b1;
                ram_waddr = load_cnt - ADDR_W'(1);
                ram_wdata = rom_q;
            end else if (state == ST_WR_COMMIT && wr_valid_q) begin
                ram_we    = 1'b1;
                ram_waddr = wr_addr_q;
                ram_wdata = wr_type_q;
            end
        end
    end

    always_ff @(posedge clock_50) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
    end

    // Display read port; a same-cycle write is seen only on the next read.
    always_ff @(posedge clock_50) begin
        if (!reset)
            type_out <= '0;
        else if (ready_next && in_grid(x_in, y_in))
            type_out <= ram[tile_addr(x_in, y_in)];
        else
            type_out <= '0;
    end

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            state        <= ST_INIT;
            load_cnt     <= '0;
            ready        <= 1'b0;
            wr_ack       <= 1'b0;
            orb_count    <= '0;
            level_clear  <= 1'b0;
            restore_pend <= 1'b0;
            wr_addr_q    <= '0;
            wr_type_q    <= '0;
            wr_valid_q   <= 1'b0;
            old_q        <= '0;
        end else begin
            state       <= state_next;
            ready       <= ready_next;
            wr_ack      <= (state_next == ST_WR_COMMIT);
            level_clear <= 1'b0;

            // A restore arriving mid-write is held until the write finishes;
            // one arriving during a load is redundant and dropped.
            if (state_next == ST_INIT)
                restore_pend <= 1'b0;
            else if (restore)
                restore_pend <= 1'b1;

            if (state_next == ST_INIT)
                load_cnt <= (state == ST_INIT) ? load_cnt + ADDR_W'(1) : '0;

            case (state)
                ST_INIT: begin
                    if (load_cnt == '0)
                        orb_count <= '0;
                    else if (is_orb(rom_q) && orb_count != ORB_MAX)
                        orb_count <= orb_count + CNT_W'(1);
                end
                ST_IDLE: begin
                    if (state_next == ST_WR_READ) begin
                        wr_addr_q  <= tile_addr(wr_x, wr_y);
                        wr_type_q  <= wr_type;
                        wr_valid_q <= in_grid(wr_x, wr_y);
                    end
                end
                ST_WR_READ: begin
                    old_q <= wr_valid_q ? ram[wr_addr_q] : TILE_BLACK;
                end
                ST_WR_COMMIT: begin
                    if (wr_valid_q) begin
                        if (is_orb(old_q) && !is_orb(wr_type_q) && orb_count != '0) begin
                            orb_count <= orb_count - CNT_W'(1);
                            if (orb_count == CNT_W'(1))
                                level_clear <= 1'b1;
                        end else if (!is_orb(old_q) && is_orb(wr_type_q) &&
                                     orb_count != ORB_MAX) begin
                            orb_count <= orb_count + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_map_tile_store.sv
module tb_map_tile_store;

    logic       clock_50 = 1'b0;
    logic       reset    = 1'b0;
    logic [4:0] x_in     = '0;
    logic [4:0] y_in     = '0;
    logic [3:0] type_out;
    logic       wr_req   = 1'b0;
    logic [4:0] wr_x     = '0;
    logic [4:0] wr_y     = '0;
    logic [3:0] wr_type  = '0;
    logic       wr_ack;
    logic       restore  = 1'b0;
    logic       ready;
    logic [8:0] orb_count;
    logic       level_clear;

    map_tile_store dut (
        .clock_50    (clock_50),
        .reset       (reset),
        .x_in        (x_in),
        .y_in        (y_in),
        .type_out    (type_out),
        .wr_req      (wr_req),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_type     (wr_type),
        .wr_ack      (wr_ack),
        .restore     (restore),
        .ready       (ready),
        .orb_count   (orb_count),
        .level_clear (level_clear)
    );

    always #10 clock_50 = ~clock_50;

    int checks = 0;
    int errors = 0;
    int mdl [21][21];
    int base_orbs;
    int exp_orbs;

    typedef struct {
        int x;
        int y;
        int t;
        int d_orb;
        int rd;
    } wvec_t;

    wvec_t wtab [9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference image of the default level, written from the level layout.
    function automatic int rom_img(input int x, input int y);
        bit border, corner, pillar, gap;
        border = (x == 0) || (x == 20) || (y == 0) || (y == 20);
        corner = (x == 1 || x == 19) && (y == 1 || y == 19);
        pillar = ((x % 4) == 2) && ((y % 4) == 2);
        gap    = ((x + y) % 7) == 0;
        if (border)             return 3;
        if (corner)             return 1;
        if (x == 10 && y == 10) return 4;
        if (pillar)             return 3;
        if (gap)                return 0;
        return 2;
    endfunction

    function automatic bit orb(input int t);
        return (t == 1) || (t == 2);
    endfunction

    task automatic load_model();
        base_orbs = 0;
        for (int yy = 0; yy < 21; yy++)
            for (int xx = 0; xx < 21; xx++) begin
                mdl[yy][xx] = rom_img(xx, yy);
                if (orb(mdl[yy][xx])) base_orbs++;
            end
        exp_orbs = base_orbs;
    endtask

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 1000) begin
            tick();
            n++;
        end
        check(name, n, 442);
    endtask

    task automatic sweep(input string name);
        for (int yy = 0; yy < 21; yy++)
            for (int xx = 0; xx < 21; xx++) begin
                x_in = 5'(xx);
                y_in = 5'(yy);
                tick();
                check($sformatf("%s(%0d,%0d)", name, xx, yy), int'(type_out), mdl[yy][xx]);
            end
        x_in = 5'd21;
        y_in = 5'd4;
        tick();
        check({name, "_x21"}, int'(type_out), 0);
    endtask

    task automatic do_write(input int x, input int y, input int t,
                            output int lat, output int clr);
        wr_x    = 5'(x);
        wr_y    = 5'(y);
        wr_type = 4'(t);
        wr_req  = 1'b1;
        lat = 0;
        clr = 0;
        while (!wr_ack && lat < 20) begin
            tick();
            lat++;
            clr += int'(level_clear);
        end
        wr_req = 1'b0;
        repeat (3) begin
            tick();
            clr += int'(level_clear);
        end
    endtask

    task automatic read_at(input int x, input int y, output int v);
        x_in = 5'(x);
        y_in = 5'(y);
        tick();
        v = int'(type_out);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, clr, v, clr_sum, lx, ly, n;
        bit acked;

        wtab[0] = '{5, 7, 0, -1, 0};
        wtab[1] = '{5, 7, 2, 1, 2};
        wtab[2] = '{1, 1, 2, 0, 2};
        wtab[3] = '{0, 0, 1, 1, 1};
        wtab[4] = '{0, 0, 3, -1, 3};
        wtab[5] = '{10, 10, 4, 0, 4};
        wtab[6] = '{22, 3, 2, 0, 0};
        wtab[7] = '{3, 25, 1, 0, 0};
        wtab[8] = '{20, 20, 0, 0, 0};

        load_model();

        // Reset state and initial load
        repeat (3) tick();
        check("rst_type_out", int'(type_out), 0);
        check("rst_wr_ack", int'(wr_ack), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_orb_count", int'(orb_count), 0);
        check("rst_level_clear", int'(level_clear), 0);
        reset = 1'b1;
        wait_ready("init_cycles");
        check("init_orb_count", int'(orb_count), base_orbs);
        sweep("rom_sweep");

        // Directed writes
        for (int i = 0; i < 9; i++) begin
            do_write(wtab[i].x, wtab[i].y, wtab[i].t, lat, clr);
            check($sformatf("wr%0d_ack_latency", i), lat, 2);
            exp_orbs += wtab[i].d_orb;
            check($sformatf("wr%0d_orb_count", i), int'(orb_count), exp_orbs);
            check($sformatf("wr%0d_level_clear", i), clr, 0);
            read_at(wtab[i].x, wtab[i].y, v);
            check($sformatf("wr%0d_readback", i), v, wtab[i].rd);
            if (wtab[i].x < 21 && wtab[i].y < 21)
                mdl[wtab[i].y][wtab[i].x] = wtab[i].t;
        end

        // Reduce the map to a single orb, then eat it
        clr_sum = 0;
        for (int yy = 0; yy < 21; yy++)
            for (int xx = 0; xx < 21; xx++)
                if (orb(mdl[yy][xx]) && exp_orbs > 1) begin
                    do_write(xx, yy, 0, lat, clr);
                    clr_sum += clr;
                    mdl[yy][xx] = 0;
                    exp_orbs--;
                end
        check("clear_no_early_pulse", clr_sum, 0);
        check("single_orb_count", int'(orb_count), 1);
        lx = 0;
        ly = 0;
        for (int yy = 0; yy < 21; yy++)
            for (int xx = 0; xx < 21; xx++)
                if (orb(mdl[yy][xx])) begin
                    lx = xx;
                    ly = yy;
                end
        do_write(lx, ly, 0, lat, clr);
        check("last_orb_count", int'(orb_count), 0);
        check("level_clear_once", clr, 1);
        do_write(lx, ly, 0, lat, clr);
        check("rewrite_no_pulse", clr, 0);
        check("rewrite_count", int'(orb_count), 0);

        // restore during WR_COMMIT
        wr_x = 5'd5; wr_y = 5'd7; wr_type = 4'd2; wr_req = 1'b1;
        n = 0;
        while (!wr_ack && n < 20) begin
            tick();
            n++;
        end
        acked = wr_ack;
        check("restore_commit_ack", int'(acked), 1);
        restore = 1'b1;
        wr_req  = 1'b0;
        tick();
        restore = 1'b0;
        check("restore_commit_ready_low", int'(ready), 0);
        wait_ready("restore_commit_cycles");
        load_model();
        check("restore_orb_count", int'(orb_count), base_orbs);
        sweep("restore_sweep");

        // restore during WR_READ is latched until the write completes
        wr_x = 5'd5; wr_y = 5'd7; wr_type = 4'd0; wr_req = 1'b1;
        tick();
        restore = 1'b1;
        tick();
        restore = 1'b0;
        wr_req  = 1'b0;
        check("latched_restore_ack", int'(wr_ack), 1);
        check("latched_restore_ready_hi", int'(ready), 1);
        tick();
        check("latched_restore_ready_low", int'(ready), 0);
        wait_ready("latched_restore_cycles");
        check("latched_restore_orbs", int'(orb_count), base_orbs);

        // reset around cycle 200 of a reload restarts it from address 0
        restore = 1'b1;
        tick();
        restore = 1'b0;
        check("restore_idle_ready_low", int'(ready), 0);
        repeat (199) tick();
        reset = 1'b0;
        tick();
        check("midinit_reset_ready", int'(ready), 0);
        check("midinit_reset_orbs", int'(orb_count), 0);
        reset = 1'b1;
        wait_ready("midinit_restart_cycles");
        check("midinit_orb_count", int'(orb_count), base_orbs);

        // out-of-range write is acked and ignored
        do_write(22, 3, 0, lat, clr);
        check("oor_ack_latency", lat, 2);
        check("oor_orb_count", int'(orb_count), base_orbs);
        read_at(22, 3, v);
        check("oor_read", v, 0);
        read_at(1, 4, v);
        check("oor_alias_tile", v, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
